req_arb_32to5: RTL and testbench

- Sequential 32-request round-robin arbiter/encoder; the inverse stage of the 5-to-32 one-hot decoder.
- Collects request bits from 32 sources into a pending register and picks one by round-robin.
- Offers the winner as a 5-bit index with a valid/ack handshake. The index feeds the decoder's x input and valid feeds its en input, so the decoder output is the one-hot grant.

---
 rtl/req_arb_32to5.sv | 165 ++++++++++++++++
 tb/tb_req_arb_32to5.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/req_arb_32to5.sv
// ---------------------------------------------------------------------------
// req_arb_32to5
//
// Sequential 32-request arbiter/encoder. Request bits from 32 sources are
// collected into a pending register. One pending source is picked and offered
// as a 5-bit index with a valid/ack handshake. idx drives the downstream
// 5-to-32 decoder's x input and valid drives its en input, so the decoder
// output is the one-hot grant.
//
// Handshake: an offer is presented while valid=1 and idx is held stable until
// the consumer returns ack=1 on a rising edge. That edge completes the
// transfer: the offered pending bit is cleared and valid drops for at least
// one cycle. ack while valid=0 is ignored, and en=0 never withdraws an offer.
//
// Build option:
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest pending index wins,
//                                   no round-robin pointer.
//                      undefined -> round-robin from pointer ptr (default).
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous, active-high reset
//   en       in   1   block enable; gates request capture and new offers
//   req      in   32  request bits; any assertion marks that source pending
//   ack      in   1   consumer accepts the current offer (valid=1 only)
//   idx      out  5   index of the offered source
//   valid    out  1   an offer is presented on idx
//   pending  out  32  registered pending-request vector
// ---------------------------------------------------------------------------
module req_arb_32to5 #(
    parameter int NUM_REQ = 32,
    parameter int IDX_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ack,
    output logic [IDX_W-1:0]   idx,
    output logic               valid,
    output logic [NUM_REQ-1:0] pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic                 take;
    logic [NUM_REQ-1:0]   clr;
    logic [NUM_REQ-1:0]   pending_kept;
    logic [NUM_REQ-1:0]   pending_nxt;

    // A transfer completes on an edge where an offer is up and ack is high.
    assign take  = (state == OFFER) && ack;
    assign valid = (state == OFFER);

    // ------------------------------------------------------------------
    // Pending register. The clear mask is applied before the new requests
    // are OR-ed in, so a request arriving in the same cycle as the ack that
    // clears it survives (set wins).
    // ------------------------------------------------------------------
    assign clr          = take ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx) : '0;
    assign pending_kept = pending & ~clr;
    assign pending_nxt  = en ? (pending_kept | req) : pending_kept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    // ------------------------------------------------------------------
    // Fixed priority: scan downward so the lowest set index is the last
    // assignment and therefore the winner.
    // ------------------------------------------------------------------
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_idx   = IDX_W'(i);
                win_found = 1'b1;
            end
        end
    end
`else
    // ------------------------------------------------------------------
    // Round-robin: ptr is the first position scanned. The scan position is
    // computed in IDX_W bits so it wraps 31 -> 0 by plain overflow, and all
    // 32 positions are visited, so any nonzero pending yields a winner.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= idx + IDX_W'(1);
        end
    end

    always_comb begin
        logic [IDX_W-1:0] pos;
        win_idx   = '0;
        win_found = 1'b0;
        pos       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = ptr + IDX_W'(i);
            if (!win_found && pending[pos]) begin
                win_idx   = pos;
                win_found = 1'b1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Offer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Offer FSM: next state. Arbitration looks only at the registered
    // pending vector, so a request needs one edge to land in pending and a
    // second edge to become an offer. idx keeps its last value in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (en && win_found) begin
                    idx_nxt   = win_idx;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_req_arb_32to5.sv
// ---------------------------------------------------------------------------
// tb_req_arb_32to5
//
// Bench for req_arb_32to5. A per-cycle vector table covers reset, enable
// gating and a single request pulse; hand-written sequences cover the
// round-robin order, pointer wrap, set-wins, offer hold with en=0, the
// fixed-priority difference and asynchronous reset mid-offer. Expected offer
// indices go into exp_q before the stimulus is driven and are popped by a
// monitor each time valid rises.
// ---------------------------------------------------------------------------
module tb_req_arb_32to5;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] req;
    logic        ack;
    logic [4:0]  idx;
    logic        valid;
    logic [31:0] pending;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];
    logic       prev_valid = 1'b0;

    req_arb_32to5 dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .ack     (ack),
        .idx     (idx),
        .valid   (valid),
        .pending (pending)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive req for one cycle
    task automatic pulse(input logic [31:0] r);
        req = r;
        tick();
        req = '0;
    endtask

    // wait (bounded) until an offer is presented
    task automatic wait_offer(input string name);
        int n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!valid) begin
            failures++;
            $display("FAIL %s: got no offer within 40 cycles, expected valid=1", name);
        end
    endtask

    // accept the current offer, optionally with a simultaneous request
    task automatic ack_offer(input string name, input logic [31:0] r);
        req = r;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        req = '0;
        check(name, {31'b0, valid}, 32'h0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        #1;
        if (valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL offer_idx: got unexpected offer idx=%0d, expected none", idx);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check("offer_idx", {27'b0, idx}, {27'b0, e});
            end
        end
        prev_valid = valid;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        en;
        logic [31:0] req;
        logic        ack;
        logic        exp_valid;
        logic [4:0]  exp_idx;
        logic [31:0] exp_pending;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // en req ack | valid idx pending (after the edge)
        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0009, 1'b0, 1'b0, 5'd0, 32'h9};
        vecs[4] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 5'd0, 32'h9};
        vecs[5] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 5'd0, 32'h8};
        vecs[6] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 5'd3, 32'h8};
        vecs[7] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 5'd3, 32'h0};
        vecs[8] = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 5'd3, 32'h0};
        vecs[9] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 5'd3, 32'h0};

        rst = 1'b1;
        en  = 1'b0;
        req = '0;
        ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'b0, valid}, 32'h0);
        check("reset_idx", {27'b0, idx}, 32'h0);
        check("reset_pending", pending, 32'h0);
        rst = 1'b0;

        // table: enable gating, single pulse 0x9 -> offers 0 then 3
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd3);
        for (int i = 0; i < 10; i++) begin
            en  = vecs[i].en;
            req = vecs[i].req;
            ack = vecs[i].ack;
            tick();
            check($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_idx", i), {27'b0, idx}, {27'b0, vecs[i].exp_idx});
            check($sformatf("vec%0d_pending", i), pending, vecs[i].exp_pending);
        end
        en  = 1'b1;
        req = '0;
        ack = 1'b0;

        // round-robin order after a grant of 3 with 0x22 pending
`ifdef ARB_FIXED_PRIO_EN
        exp_q.push_back(5'd3); exp_q.push_back(5'd1); exp_q.push_back(5'd5);
`else
        exp_q.push_back(5'd3); exp_q.push_back(5'd5); exp_q.push_back(5'd1);
`endif
        pulse(32'h0000_0008);
        wait_offer("rr_offer_a");
        pulse(32'h0000_0022);
        ack_offer("rr_ack_a", '0);
        check("rr_pending_after_3", pending, 32'h22);
        wait_offer("rr_offer_b");
        ack_offer("rr_ack_b", '0);
        wait_offer("rr_offer_c");
        ack_offer("rr_ack_c", '0);
        check("rr_pending_end", pending, 32'h0);

        // pointer wrap: grant 30 -> ptr 31, then 0x8000_0001
`ifdef ARB_FIXED_PRIO_EN
        exp_q.push_back(5'd30); exp_q.push_back(5'd0); exp_q.push_back(5'd31);
`else
        exp_q.push_back(5'd30); exp_q.push_back(5'd31); exp_q.push_back(5'd0);
`endif
        pulse(32'h4000_0000);
        wait_offer("wrap_offer_a");
        pulse(32'h8000_0001);
        ack_offer("wrap_ack_a", '0);
        check("wrap_pending", pending, 32'h8000_0001);
        wait_offer("wrap_offer_b");
        ack_offer("wrap_ack_b", '0);
        wait_offer("wrap_offer_c");
        ack_offer("wrap_ack_c", '0);
        check("wrap_pending_end", pending, 32'h0);

        // set wins over clear, then hold the re-offer with en=0
        exp_q.push_back(5'd2);
        exp_q.push_back(5'd2);
        pulse(32'h0000_0004);
        wait_offer("setwin_offer");
        ack_offer("setwin_ack", 32'h0000_0004);
        check("setwin_pending", pending, 32'h4);
        wait_offer("setwin_reoffer");
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("hold%0d_valid", c), {31'b0, valid}, 32'h1);
            check($sformatf("hold%0d_idx", c), {27'b0, idx}, 32'h2);
        end
        ack_offer("hold_ack_en0", '0);
        check("hold_pending_cleared", pending, 32'h0);
        en = 1'b1;

        // 0x30 pending after a grant of 4 with 4 re-requested
`ifdef ARB_FIXED_PRIO_EN
        exp_q.push_back(5'd4); exp_q.push_back(5'd4); exp_q.push_back(5'd5);
`else
        exp_q.push_back(5'd4); exp_q.push_back(5'd5); exp_q.push_back(5'd4);
`endif
        pulse(32'h0000_0030);
        wait_offer("prio_offer_a");
        ack_offer("prio_ack_a", 32'h0000_0010);
        check("prio_pending", pending, 32'h30);
        wait_offer("prio_offer_b");
        ack_offer("prio_ack_b", '0);
        wait_offer("prio_offer_c");
        ack_offer("prio_ack_c", '0);
        check("prio_pending_end", pending, 32'h0);

        // asynchronous reset in the middle of an offer of 7
        exp_q.push_back(5'd7);
        pulse(32'h0000_0080);
        wait_offer("rst_offer");
        check("rst_pre_idx", {27'b0, idx}, 32'h7);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_valid", {31'b0, valid}, 32'h0);
        check("rst_async_idx", {27'b0, idx}, 32'h0);
        check("rst_async_pending", pending, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // pointer back at 0 after reset: 0x42 -> 1 then 6
        exp_q.push_back(5'd1);
        exp_q.push_back(5'd6);
        pulse(32'h0000_0042);
        wait_offer("post_rst_offer_a");
        ack_offer("post_rst_ack_a", '0);
        wait_offer("post_rst_offer_b");
        ack_offer("post_rst_ack_b", '0);
        check("post_rst_pending", pending, 32'h0);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
